// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - serialises host config words MSB-first onto a tile configuration shift chain
// Optional readback of previous chain contents: define CONFIG_CHAIN_LOADER_READBACK_EN.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 24,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data_out,
  output logic                  chain_enable,
  input  logic                  chain_data_in,
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] CHAIN_LEN_C = COUNT_WIDTH'(CHAIN_LENGTH);
  localparam logic [COUNT_WIDTH-1:0] WORD_W_C    = COUNT_WIDTH'(WORD_WIDTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [BW-1:0]           bits_q, bits_d;
  logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    enable_q;
  logic                    data_q, data_d;
  logic [COUNT_WIDTH-1:0]  remaining;
  logic                    last_bit;

  assign remaining = CHAIN_LEN_C - count_q;
  assign last_bit  = (bits_q == BW'(1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = WAIT_WORD;
          count_d = '0;
        end
      end
      WAIT_WORD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (word_valid) begin
          shreg_d = word_data;
          // a final partial word only sends its top bits; the low bits never leave shreg
          bits_d  = (remaining < WORD_W_C) ? BW'(remaining) : BW'(WORD_WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          shreg_d = shreg_q << 1;
          count_d = count_q + COUNT_WIDTH'(1);
          bits_d  = bits_q - BW'(1);
          if (last_bit) begin
            state_d = ((count_q + COUNT_WIDTH'(1)) == CHAIN_LEN_C) ? DONE : WAIT_WORD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // the serial output only moves while the chain is enabled, so it holds between words
    if (state_d == SHIFT) begin
      data_d = shreg_d[WORD_WIDTH-1];
    end
  end

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      bits_q   <= '0;
      shreg_q  <= '0;
      enable_q <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      bits_q   <= bits_d;
      shreg_q  <= shreg_d;
      enable_q <= (state_d == SHIFT);
      data_q   <= data_d;
    end
  end

  assign word_ready     = (state_q == WAIT_WORD) && !abort;
  assign busy           = (state_q == WAIT_WORD) || (state_q == SHIFT);
  assign done           = (state_q == DONE);
  assign chain_enable   = enable_q;
  assign chain_data_out = data_q;

`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
  logic [WORD_WIDTH-1:0] rb_shreg_q;
  logic [WORD_WIDTH-1:0] rb_next;
  logic [WORD_WIDTH-1:0] rb_data_q;
  logic                  rb_valid_q;
  logic [BW-1:0]         word_bits_q;
  logic [BW-1:0]         rb_pad;

  // the chain shifts on the same edge, so chain_data_in is still the old far-end bit
  assign rb_next = (rb_shreg_q << 1) | WORD_WIDTH'(chain_data_in);
  assign rb_pad  = BW'(WORD_WIDTH) - word_bits_q;

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      rb_shreg_q  <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      word_bits_q <= '0;
    end else begin
      rb_valid_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        rb_shreg_q <= '0;
        rb_data_q  <= '0;
      end else if ((state_q == WAIT_WORD) && word_valid) begin
        rb_shreg_q  <= '0;
        word_bits_q <= bits_d;
      end else if (state_q == SHIFT) begin
        rb_shreg_q <= rb_next;
        if (last_bit) begin
          rb_valid_q <= 1'b1;
          rb_data_q  <= rb_next << rb_pad;
        end
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_chain_data_in;
  assign unused_chain_data_in = chain_data_in;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - directed self-checking bench for config_chain_loader
module tb_config_chain_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start24 = 1'b0, start20 = 1'b0, abort24 = 1'b0, abort20 = 1'b0;
  logic [7:0] word_data = 8'h00;
  logic       word_valid = 1'b0;
  logic       ready24, out24, en24, busy24, done24;
  logic       ready20, out20, en20, busy20, done20;
  logic       in20 = 1'b0;
  logic [23:0] sr = 24'h0;
  logic        sr_load = 1'b0;
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
  logic [7:0] rb_data24, rb_data20;
  logic       rb_valid24, rb_valid20;
  logic [7:0] rb_q[$];
`endif

  int errors = 0;
  int checks = 0;

  int cyc = 0, en24_cnt = 0, en20_cnt = 0, done24_cnt = 0, done20_cnt = 0;
  int gap24 = 0, acc24 = 0, start_cyc = 0, done_cyc = 0;
  logic [31:0] cap24 = 32'h0, cap20 = 32'h0;

  always #5 clk = ~clk;

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(24), .COUNT_WIDTH(16)) u_dut24 (
    .config_clock(clk), .config_nreset(rst_n), .start(start24), .abort(abort24),
    .word_data(word_data), .word_valid(word_valid), .word_ready(ready24),
    .chain_data_out(out24), .chain_enable(en24), .chain_data_in(sr[23]),
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    .rb_data(rb_data24), .rb_valid(rb_valid24),
`endif
    .busy(busy24), .done(done24)
  );

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20), .COUNT_WIDTH(16)) u_dut20 (
    .config_clock(clk), .config_nreset(rst_n), .start(start20), .abort(abort20),
    .word_data(word_data), .word_valid(word_valid), .word_ready(ready20),
    .chain_data_out(out20), .chain_enable(en20), .chain_data_in(in20),
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    .rb_data(rb_data20), .rb_valid(rb_valid20),
`endif
    .busy(busy20), .done(done20)
  );

  // chain of tiles modelled as one long shift register
  always @(posedge clk) begin
    if (sr_load) sr <= 24'h123456;
    else if (en24) sr <= {sr[22:0], out24};
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (en24) begin cap24 <= {cap24[30:0], out24}; en24_cnt <= en24_cnt + 1; end
    if (en20) begin cap20 <= {cap20[30:0], out20}; en20_cnt <= en20_cnt + 1; end
    if (done24) begin done24_cnt <= done24_cnt + 1; done_cyc <= cyc; end
    if (done20) done20_cnt <= done20_cnt + 1;
    if (busy24 && !en24) gap24 <= gap24 + 1;
    if (word_valid && ready24) acc24 <= acc24 + 1;
    if (start24 && !busy24) start_cyc <= cyc;
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    if (rb_valid24) rb_q.push_back(rb_data24);
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit use20);
    tick();
    if (use20) start20 = 1'b1; else start24 = 1'b1;
    tick();
    start20 = 1'b0; start24 = 1'b0;
  endtask

  task automatic wait_ready(input bit use20);
    int n = 0;
    while (!(use20 ? ready20 : ready24) && n < 200) begin tick(); n++; end
    check("word_ready", use20 ? ready20 : ready24, 1);
  endtask

  task automatic send_word(input logic [7:0] w, input bit use20);
    word_data  = w;
    word_valid = 1'b1;
    wait_ready(use20);
    tick();
  endtask

  task automatic wait_done(input bit use20);
    int n = 0;
    while (!(use20 ? done20 : done24) && n < 200) begin tick(); n++; end
    check("done_seen", use20 ? done20 : done24, 1);
    tick();
  endtask

  task automatic load3(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                       input int gap, input bit use20, input bit extra_start);
    logic [7:0] ws [3];
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    pulse_start(use20);
    for (int i = 0; i < 3; i++) begin
      if (gap > 0) begin
        word_valid = 1'b0;
        wait_ready(use20);
        repeat (gap) tick();
      end
      send_word(ws[i], use20);
      if (extra_start && i == 0) begin
        start24 = 1'b1;
        tick();
        start24 = 1'b0;
      end
    end
    word_valid = 1'b0;
    wait_done(use20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, d0, g0, a0, n;

    // reset state
    repeat (3) tick();
    check("rst_word_ready", ready24, 0);
    check("rst_chain_data_out", out24, 0);
    check("rst_chain_enable", en24, 0);
    check("rst_busy", busy24, 0);
    check("rst_done", done24, 0);
    check("rst_enable20", en20, 0);
    check("rst_busy20", busy20, 0);
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    check("rst_rb_valid", rb_valid24, 0);
    check("rst_rb_data", rb_data24, 0);
`endif
    rst_n = 1'b1;
    tick();

    // back-to-back words into the 24-bit chain
    e0 = en24_cnt; g0 = gap24; d0 = done24_cnt;
    load3(8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0);
    check("b2b_stream", {8'h00, cap24[23:0]}, 32'h00A53CF0);
    check("b2b_enable_cycles", en24_cnt - e0, 24);
    check("b2b_gap_cycles", gap24 - g0, 3);
    check("b2b_done_pulses", done24_cnt - d0, 1);
    check("b2b_latency", done_cyc - start_cyc, 28);
    check("b2b_busy_after", busy24, 0);
    check("b2b_data_hold", out24, 0);

    // 20-bit chain: last word shifts only its top 4 bits
    e0 = en20_cnt; d0 = done20_cnt;
    load3(8'hFF, 8'h00, 8'hB7, 0, 1'b1, 1'b0);
    check("len20_stream", {12'h000, cap20[19:0]}, 32'h000FF00B);
    check("len20_enable_cycles", en20_cnt - e0, 20);
    check("len20_done_pulses", done20_cnt - d0, 1);
    check("len20_data_hold", out20, 1);
    word_valid = 1'b1;
    repeat (3) tick();
    check("len20_no_ready", ready20, 0);
    check("len20_busy_after", busy20, 0);
    word_valid = 1'b0;

    // host stalls 5 cycles before every word
    e0 = en24_cnt; g0 = gap24; d0 = done24_cnt;
    load3(8'hA5, 8'h3C, 8'hF0, 5, 1'b0, 1'b0);
    check("stall_stream", {8'h00, cap24[23:0]}, 32'h00A53CF0);
    check("stall_enable_cycles", en24_cnt - e0, 24);
    check("stall_gap_cycles", gap24 - g0, 18);
    check("stall_done_pulses", done24_cnt - d0, 1);

    // abort after 10 shifted bits
    e0 = en24_cnt; d0 = done24_cnt;
    pulse_start(1'b0);
    word_data = 8'hA5; word_valid = 1'b1;
    n = 0;
    while ((en24_cnt - e0) < 10 && n < 100) begin @(negedge clk); #1; n++; end
    check("abort_bits_before", en24_cnt - e0, 10);
    abort24 = 1'b1;
    tick();
    abort24 = 1'b0; word_valid = 1'b0;
    check("abort_enable", en24, 0);
    check("abort_busy", busy24, 0);
    check("abort_ready", ready24, 0);
    repeat (4) tick();
    check("abort_no_done", done24_cnt - d0, 0);
    check("abort_bits_total", en24_cnt - e0, 10);
    e0 = en24_cnt; d0 = done24_cnt;
    load3(8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0);
    check("after_abort_stream", {8'h00, cap24[23:0]}, 32'h00A53CF0);
    check("after_abort_enable_cycles", en24_cnt - e0, 24);
    check("after_abort_done", done24_cnt - d0, 1);

    // asynchronous reset in the middle of a shift
    pulse_start(1'b0);
    word_data = 8'h3C; word_valid = 1'b1;
    n = 0;
    while (!en24 && n < 50) begin tick(); n++; end
    check("mid_shift_enable", en24, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_enable", en24, 0);
    check("async_rst_busy", busy24, 0);
    check("async_rst_ready", ready24, 0);
    word_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy24, 0);

    // start pulses while busy are ignored
    e0 = en24_cnt; d0 = done24_cnt; a0 = acc24;
    load3(8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b1);
    check("busy_start_stream", {8'h00, cap24[23:0]}, 32'h00A53CF0);
    check("busy_start_enable_cycles", en24_cnt - e0, 24);
    check("busy_start_words", acc24 - a0, 3);
    check("busy_start_done", done24_cnt - d0, 1);
    word_data = 8'h55; word_valid = 1'b1;
    repeat (3) tick();
    check("idle_no_ready", ready24, 0);
    check("idle_no_accept", acc24 - a0, 3);
    word_valid = 1'b0;

`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    // readback of a preloaded chain
    sr_load = 1'b1;
    tick();
    sr_load = 1'b0;
    rb_q.delete();
    load3(8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0);
    check("rb_pulses", rb_q.size(), 3);
    check("rb_word0", (rb_q.size() > 0) ? rb_q[0] : 8'hxx, 8'h12);
    check("rb_word1", (rb_q.size() > 1) ? rb_q[1] : 8'hxx, 8'h34);
    check("rb_word2", (rb_q.size() > 2) ? rb_q[2] : 8'hxx, 8'h56);
    check("rb_chain_contents", {8'h00, sr}, 32'h00A53CF0);
    check("rb_valid_idle", rb_valid24, 0);
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
